// File: rtl/stall_ctrl_pkg.sv
// Shared definitions for the pipeline stall controller and the hazard unit:
// FSM state encodings and the default branch-wait watchdog limit.
package stall_ctrl_pkg;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_BR_WAIT = 1'b1
  } ctrl_state_e;

  localparam int DEF_MAX_WAIT = 8;

endpackage

// File: rtl/stall_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over enable.
module stall_ctrl_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != {W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/stall_ctrl.sv
// Pipeline stall controller: drives PC / IF/ID / ID/EX enables and flushes.
// Define STALL_CTRL_PERF_EN to add saturating load/branch stall counters.
module stall_ctrl
  import stall_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = DEF_MAX_WAIT
`ifdef STALL_CTRL_PERF_EN
  , parameter int CNT_W  = 32
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_stall,
  input  logic        branch_stall,
  input  logic        branch_resolved,
  input  logic        ext_stall,
  output logic        pc_write_en,
  output logic        if_id_write_en,
  output logic        if_id_flush,
  output logic        id_ex_write_en,
  output logic        id_ex_flush,
  output logic        br_timeout,
  output ctrl_state_e dbg_state
`ifdef STALL_CTRL_PERF_EN
  , output logic [CNT_W-1:0] load_stall_cnt
  , output logic [CNT_W-1:0] branch_stall_cnt
`endif
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  ctrl_state_e       state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              wait_last;

  assign wait_last = (wait_cnt == WAIT_LAST);
  assign dbg_state = state;

  // Enables/flushes are combinational so the pipeline registers react in the same cycle.
  always_comb begin
    pc_write_en    = 1'b0;
    if_id_write_en = 1'b0;
    if_id_flush    = 1'b0;
    id_ex_write_en = 1'b0;
    id_ex_flush    = 1'b0;
    if (rst) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (!ext_stall) begin
      case (state)
        ST_RUN: begin
          if (load_stall) begin
            id_ex_write_en = 1'b1;
            id_ex_flush    = 1'b1;
          end else if (branch_stall) begin
            if_id_write_en = 1'b1;
            if_id_flush    = 1'b1;
            id_ex_write_en = 1'b1;
          end else begin
            pc_write_en    = 1'b1;
            if_id_write_en = 1'b1;
            id_ex_write_en = 1'b1;
          end
        end
        ST_BR_WAIT: begin
          // A watchdog expiry releases the PC exactly like a resolve.
          pc_write_en    = branch_resolved | wait_last;
          if_id_write_en = 1'b1;
          if_id_flush    = 1'b1;
          id_ex_write_en = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_RUN;
      wait_cnt   <= '0;
      br_timeout <= 1'b0;
    end else if (!ext_stall) begin
      case (state)
        ST_RUN: begin
          if (!load_stall && branch_stall) begin
            state    <= ST_BR_WAIT;
            wait_cnt <= '0;
          end
        end
        ST_BR_WAIT: begin
          if (branch_resolved) begin
            state    <= ST_RUN;
            wait_cnt <= '0;
          end else if (wait_last) begin
            state      <= ST_RUN;
            wait_cnt   <= '0;
            br_timeout <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

`ifdef STALL_CTRL_PERF_EN
  stall_ctrl_sat_counter #(.W(CNT_W)) u_load_cnt (
    .clk (clk),
    .clr (rst),
    .en  (!ext_stall && (state == ST_RUN) && load_stall),
    .cnt (load_stall_cnt)
  );

  stall_ctrl_sat_counter #(.W(CNT_W)) u_branch_cnt (
    .clk (clk),
    .clr (rst),
    .en  (!ext_stall && (state == ST_BR_WAIT)),
    .cnt (branch_stall_cnt)
  );
`endif

endmodule

// File: tb/tb_stall_ctrl.sv
// Directed bench for stall_ctrl (MAX_WAIT=4): literal per-cycle expectations
// plus a transaction-level model of the branch-wait / watchdog rules.
module tb_stall_ctrl;
  import stall_ctrl_pkg::*;

  localparam int MAX_WAIT = 4;
  localparam int CNT_W    = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic load_stall = 1'b0, branch_stall = 1'b0, branch_resolved = 1'b0, ext_stall = 1'b0;
  logic pc_write_en, if_id_write_en, if_id_flush, id_ex_write_en, id_ex_flush, br_timeout;
  ctrl_state_e dbg_state;
`ifdef STALL_CTRL_PERF_EN
  logic [CNT_W-1:0] load_stall_cnt, branch_stall_cnt;
`endif

  int errors = 0;
  int checks = 0;
  logic [6:0] exp_q[$];
  bit done = 1'b0;

  stall_ctrl #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk             (clk),
    .rst             (rst),
    .load_stall      (load_stall),
    .branch_stall    (branch_stall),
    .branch_resolved (branch_resolved),
    .ext_stall       (ext_stall),
    .pc_write_en     (pc_write_en),
    .if_id_write_en  (if_id_write_en),
    .if_id_flush     (if_id_flush),
    .id_ex_write_en  (id_ex_write_en),
    .id_ex_flush     (id_ex_flush),
    .br_timeout      (br_timeout),
    .dbg_state       (dbg_state)
`ifdef STALL_CTRL_PERF_EN
    , .load_stall_cnt   (load_stall_cnt)
    , .branch_stall_cnt (branch_stall_cnt)
`endif
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // waiting: a branch is outstanding in EX; waited: cycles already spent waiting.
  bit waiting = 1'b0;
  int waited = 0;
  bit timed_out = 1'b0;
  int m_load_cnt = 0;
  int m_branch_cnt = 0;

  always @(posedge clk) begin
    if (rst) begin
      waiting = 1'b0; waited = 0; timed_out = 1'b0;
      m_load_cnt = 0; m_branch_cnt = 0;
    end else if (!ext_stall) begin
      if (!waiting) begin
        if (load_stall) m_load_cnt++;
        else if (branch_stall) begin waiting = 1'b1; waited = 0; end
      end else begin
        m_branch_cnt++;
        if (branch_resolved) waiting = 1'b0;
        else if (waited + 1 == MAX_WAIT) begin waiting = 1'b0; timed_out = 1'b1; end
        else waited++;
      end
    end
  end

  // {pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush, br_timeout, in_br_wait}
  function automatic logic [6:0] model_out();
    logic [4:0] ctl;
    if (rst) ctl = 5'b00101;
    else if (ext_stall) ctl = 5'b00000;
    else if (!waiting && load_stall) ctl = 5'b00011;
    else if (!waiting && branch_stall) ctl = 5'b01110;
    else if (!waiting) ctl = 5'b11010;
    else if (branch_resolved || (waited == MAX_WAIT - 1)) ctl = 5'b11110;
    else ctl = 5'b01110;
    return {ctl, timed_out, waiting};
  endfunction

  // ---------------- driver ----------------
  // in = {rst, load_stall, branch_stall, branch_resolved, ext_stall}
  task automatic step(input logic [4:0] in, input logic [6:0] exp);
    @(posedge clk);
    #1;
    {rst, load_stall, branch_stall, branch_resolved, ext_stall} = in;
    exp_q.push_back(exp);
  endtask

  // ---------------- scoreboard / compare ----------------
  always @(negedge clk) begin
    logic [6:0] act, lit, mdl;
    if (exp_q.size() != 0) begin
      lit = exp_q.pop_front();
      mdl = model_out();
      act = {pc_write_en, if_id_write_en, if_id_flush, id_ex_write_en, id_ex_flush,
             br_timeout, (dbg_state == ST_BR_WAIT)};
      checks++;
      if (act !== lit) begin
        errors++;
        $display("FAIL vec_literal t=%0t actual=%b expected=%b", $time, act, lit);
      end
      checks++;
      if (act !== mdl) begin
        errors++;
        $display("FAIL vs_model t=%0t actual=%b expected=%b", $time, act, mdl);
      end
      checks++;
      if (mdl !== lit) begin
        errors++;
        $display("FAIL model_pin t=%0t model=%b expected=%b", $time, mdl, lit);
      end
`ifdef STALL_CTRL_PERF_EN
      checks++;
      if (load_stall_cnt !== CNT_W'(m_load_cnt)) begin
        errors++;
        $display("FAIL load_stall_cnt actual=%0d expected=%0d", load_stall_cnt, m_load_cnt);
      end
      checks++;
      if (branch_stall_cnt !== CNT_W'(m_branch_cnt)) begin
        errors++;
        $display("FAIL branch_stall_cnt actual=%0d expected=%0d", branch_stall_cnt, m_branch_cnt);
      end
`endif
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    // reset held 2 cycles with load_stall asserted
    step(5'b11000, 7'b0010100);
    step(5'b11000, 7'b0010100);
    step(5'b00000, 7'b1101000);
    // single load stall, then normal
    step(5'b01000, 7'b0001100);
    step(5'b00000, 7'b1101000);
    // branch, two unresolved waits, resolve on the third wait cycle
    step(5'b00100, 7'b0111000);
    step(5'b00000, 7'b0111001);
    step(5'b00000, 7'b0111001);
    step(5'b00010, 7'b1111001);
    step(5'b00000, 7'b1101000);
    // load and branch together: load wins, stays in RUN
    step(5'b01100, 7'b0001100);
    step(5'b00000, 7'b1101000);
    // ext_stall mid-wait swallows branch_resolved, then resolve alone
    step(5'b00100, 7'b0111000);
    step(5'b00011, 7'b0000001);
    step(5'b00011, 7'b0000001);
    step(5'b00010, 7'b1111001);
    step(5'b00000, 7'b1101000);
    // branch_resolved in RUN ignored; ext_stall in RUN freezes everything
    step(5'b00010, 7'b1101000);
    step(5'b01001, 7'b0000000);
    step(5'b00000, 7'b1101000);
    // watchdog: four unresolved waits (stalls ignored while waiting)
    step(5'b00100, 7'b0111000);
    step(5'b00000, 7'b0111001);
    step(5'b01100, 7'b0111001);
    step(5'b00000, 7'b0111001);
    step(5'b00000, 7'b1111001);
    step(5'b00000, 7'b1101010);
    step(5'b01000, 7'b0001110);
    step(5'b00000, 7'b1101010);
    // sticky until reset
    step(5'b10000, 7'b0010110);
    step(5'b00000, 7'b1101000);
    @(posedge clk);
    done = 1'b1;
  end

  initial begin
    int budget = 0;
    while (!(done && exp_q.size() == 0) && budget < 2000) begin
      @(posedge clk);
      budget++;
    end
    @(negedge clk);
    if (budget >= 2000) begin
      errors++;
      checks++;
      $display("FAIL run_budget actual=%0d cycles expected<2000", budget);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
